// File: rtl/pll_reconfig_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reconfig_sequencer
// Drives the Avalon-MM management port of a reconfigurable PLL. On a start
// request it writes the mode register, streams the selected clock plan's
// counter / fractional-divider registers, triggers reconfiguration and waits
// for a stable lock, retrying the whole sequence on a lock timeout. The core
// is held in reset whenever the PLL clocks cannot be trusted.
// -----------------------------------------------------------------------------
module pll_reconfig_sequencer #(
    parameter int NUM_MODES    = 2,
    parameter int NUM_REGS     = 8,
    parameter int ADDR_W       = 6,
    parameter int DATA_W       = 32,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int LOCK_STABLE  = 1024,
    parameter int RETRY_MAX    = 3,
    localparam int MODE_W      = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
    input  logic                                 refclk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [MODE_W-1:0]                    mode_sel,
    input  logic [NUM_MODES*NUM_REGS*ADDR_W-1:0] cfg_addr,
    input  logic [NUM_MODES*NUM_REGS*DATA_W-1:0] cfg_data,
    output logic [ADDR_W-1:0]                    mgmt_address,
    output logic                                 mgmt_write,
    output logic [DATA_W-1:0]                    mgmt_writedata,
    input  logic                                 mgmt_waitrequest,
    input  logic                                 pll_locked,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 error,
    output logic [MODE_W-1:0]                    active_mode,
    output logic                                 hold_reset
);

    // ---------------------------------------------------------------------
    // Derived sizes
    // ---------------------------------------------------------------------
    localparam int ENTRIES = NUM_MODES * NUM_REGS;
    localparam int ENT_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int ST_W    = $clog2(LOCK_STABLE + 1);
    localparam int TO_W    = $clog2(LOCK_TIMEOUT + 1);
    localparam int RT_W    = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

    // Fixed register map of the reconfiguration IP
    localparam logic [ADDR_W-1:0] MODE_REG_ADDR  = ADDR_W'(0);
    localparam logic [DATA_W-1:0] MODE_REG_DATA  = DATA_W'(0);   // waitrequest mode
    localparam logic [ADDR_W-1:0] START_REG_ADDR = ADDR_W'(2);
    localparam logic [DATA_W-1:0] START_REG_DATA = DATA_W'(1);

    typedef enum logic [3:0] {
        ST_INIT_LOCK = 4'd0,
        ST_IDLE      = 4'd1,
        ST_MODE_WR   = 4'd2,
        ST_PARAM_WR  = 4'd3,
        ST_START_WR  = 4'd4,
        ST_WAIT_IP   = 4'd5,
        ST_LOCK_WAIT = 4'd6,
        ST_DONE      = 4'd7,
        ST_FAIL      = 4'd8
    } state_t;

    // ---------------------------------------------------------------------
    // Declarations
    // ---------------------------------------------------------------------
    state_t              state_r;
    state_t              state_nxt_s;

    logic                meta_r;
    logic                locked_sync_r;
    logic [ST_W-1:0]     stab_cnt_r;
    logic                stable_s;

    logic [MODE_W-1:0]   mode_r;
    logic [IDX_W-1:0]    idx_r;
    logic [TO_W-1:0]     to_cnt_r;
    logic [RT_W-1:0]     retry_r;

    logic [MODE_W-1:0]   mode_nxt_s;
    logic [IDX_W-1:0]    idx_nxt_s;
    logic [TO_W-1:0]     to_nxt_s;
    logic [RT_W-1:0]     retry_nxt_s;

    logic                wr_nxt_s;
    logic [ADDR_W-1:0]   addr_nxt_s;
    logic [DATA_W-1:0]   data_nxt_s;
    logic                busy_nxt_s;
    logic                done_nxt_s;
    logic                error_nxt_s;
    logic [MODE_W-1:0]   active_nxt_s;
    logic                hold_nxt_s;

    logic                xfer_done_s;
    logic                mode_ok_s;
    logic                last_param_s;
    logic [IDX_W-1:0]    idx_inc_s;
    logic [ENT_W-1:0]    ent_first_s;
    logic [ENT_W-1:0]    ent_next_s;

    logic [ADDR_W-1:0]   tab_addr_s [ENTRIES];
    logic [DATA_W-1:0]   tab_data_s [ENTRIES];

    // ---------------------------------------------------------------------
    // Configuration table unpacking: entry (m,r) lives at m*NUM_REGS+r
    // ---------------------------------------------------------------------
    for (genvar g = 0; g < ENTRIES; g++) begin : g_tab
        assign tab_addr_s[g] = cfg_addr[g*ADDR_W +: ADDR_W];
        assign tab_data_s[g] = cfg_data[g*DATA_W +: DATA_W];
    end

    // A write completes on the first edge with write high and no waitrequest
    assign xfer_done_s  = mgmt_write & ~mgmt_waitrequest;
    assign mode_ok_s    = (int'(mode_sel) < NUM_MODES);
    assign stable_s     = (stab_cnt_r == ST_W'(LOCK_STABLE));
    assign last_param_s = (idx_r == IDX_W'(NUM_REGS - 1));

    // Clamped increment keeps the look-ahead table index inside the array
    assign idx_inc_s    = last_param_s ? idx_r : (idx_r + IDX_W'(1));
    assign ent_first_s  = ENT_W'(mode_r) * ENT_W'(NUM_REGS);
    assign ent_next_s   = ent_first_s + ENT_W'(idx_inc_s);

    // Two-flop synchroniser for the asynchronous PLL lock indication
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            meta_r        <= 1'b0;
            locked_sync_r <= 1'b0;
        end else begin
            meta_r        <= pll_locked;
            locked_sync_r <= meta_r;
        end
    end

    // Consecutive-lock counter: saturates at LOCK_STABLE, clears on any low
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            stab_cnt_r <= ST_W'(0);
        end else if (!locked_sync_r) begin
            stab_cnt_r <= ST_W'(0);
        end else if (!stable_s) begin
            stab_cnt_r <= stab_cnt_r + ST_W'(1);
        end else begin
            stab_cnt_r <= stab_cnt_r;
        end
    end

    // Sequencer state register
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_r <= ST_INIT_LOCK;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and next-output decode; every output is registered below
    always_comb begin
        state_nxt_s  = state_r;
        mode_nxt_s   = mode_r;
        idx_nxt_s    = idx_r;
        to_nxt_s     = to_cnt_r;
        retry_nxt_s  = retry_r;
        wr_nxt_s     = mgmt_write;
        addr_nxt_s   = mgmt_address;
        data_nxt_s   = mgmt_writedata;
        busy_nxt_s   = busy;
        done_nxt_s   = 1'b0;
        error_nxt_s  = error;
        active_nxt_s = active_mode;
        hold_nxt_s   = hold_reset;

        case (state_r)
            ST_INIT_LOCK: begin
                if (stable_s) begin
                    hold_nxt_s  = 1'b0;
                    state_nxt_s = ST_IDLE;
                end else begin
                    hold_nxt_s  = 1'b1;
                    state_nxt_s = ST_INIT_LOCK;
                end
            end

            // IDLE and FAIL accept a new request identically; only IDLE
            // watches for lock loss, FAIL already holds the core in reset.
            ST_IDLE, ST_FAIL: begin
                if ((state_r == ST_IDLE) && !locked_sync_r) begin
                    hold_nxt_s  = 1'b1;
                    state_nxt_s = ST_INIT_LOCK;
                end else if (start && mode_ok_s) begin
                    mode_nxt_s  = mode_sel;
                    error_nxt_s = 1'b0;
                    retry_nxt_s = RT_W'(0);
                    busy_nxt_s  = 1'b1;
                    hold_nxt_s  = 1'b1;
                    wr_nxt_s    = 1'b1;
                    addr_nxt_s  = MODE_REG_ADDR;
                    data_nxt_s  = MODE_REG_DATA;
                    state_nxt_s = ST_MODE_WR;
                end else if (start) begin
                    error_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = state_r;
                end
            end

            ST_MODE_WR: begin
                if (xfer_done_s) begin
                    idx_nxt_s   = IDX_W'(0);
                    wr_nxt_s    = 1'b1;
                    addr_nxt_s  = tab_addr_s[ent_first_s];
                    data_nxt_s  = tab_data_s[ent_first_s];
                    state_nxt_s = ST_PARAM_WR;
                end else begin
                    state_nxt_s = ST_MODE_WR;
                end
            end

            ST_PARAM_WR: begin
                if (xfer_done_s) begin
                    if (last_param_s) begin
                        wr_nxt_s    = 1'b1;
                        addr_nxt_s  = START_REG_ADDR;
                        data_nxt_s  = START_REG_DATA;
                        state_nxt_s = ST_START_WR;
                    end else begin
                        idx_nxt_s   = idx_inc_s;
                        wr_nxt_s    = 1'b1;
                        addr_nxt_s  = tab_addr_s[ent_next_s];
                        data_nxt_s  = tab_data_s[ent_next_s];
                        state_nxt_s = ST_PARAM_WR;
                    end
                end else begin
                    state_nxt_s = ST_PARAM_WR;
                end
            end

            ST_START_WR: begin
                if (xfer_done_s) begin
                    wr_nxt_s    = 1'b0;
                    state_nxt_s = ST_WAIT_IP;
                end else begin
                    state_nxt_s = ST_START_WR;
                end
            end

            // The IP keeps waitrequest high while it reprograms the PLL
            ST_WAIT_IP: begin
                if (!mgmt_waitrequest) begin
                    to_nxt_s    = TO_W'(0);
                    state_nxt_s = ST_LOCK_WAIT;
                end else begin
                    state_nxt_s = ST_WAIT_IP;
                end
            end

            ST_LOCK_WAIT: begin
                if (stable_s) begin
                    active_nxt_s = mode_r;
                    done_nxt_s   = 1'b1;
                    busy_nxt_s   = 1'b0;
                    hold_nxt_s   = 1'b0;
                    state_nxt_s  = ST_DONE;
                end else if (to_cnt_r == TO_W'(LOCK_TIMEOUT)) begin
                    if (retry_r < RT_W'(RETRY_MAX)) begin
                        retry_nxt_s = retry_r + RT_W'(1);
                        wr_nxt_s    = 1'b1;
                        addr_nxt_s  = MODE_REG_ADDR;
                        data_nxt_s  = MODE_REG_DATA;
                        state_nxt_s = ST_MODE_WR;
                    end else begin
                        error_nxt_s = 1'b1;
                        busy_nxt_s  = 1'b0;
                        state_nxt_s = ST_FAIL;
                    end
                end else begin
                    to_nxt_s    = to_cnt_r + TO_W'(1);
                    state_nxt_s = ST_LOCK_WAIT;
                end
            end

            // done is high for exactly this one cycle; start is not sampled
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end

            default: begin
                wr_nxt_s    = 1'b0;
                busy_nxt_s  = 1'b0;
                hold_nxt_s  = 1'b1;
                state_nxt_s = ST_INIT_LOCK;
            end
        endcase
    end

    // Registered outputs and sequencer bookkeeping
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            mgmt_write     <= 1'b0;
            mgmt_address   <= ADDR_W'(0);
            mgmt_writedata <= DATA_W'(0);
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            active_mode    <= MODE_W'(0);
            hold_reset     <= 1'b1;
            mode_r         <= MODE_W'(0);
            idx_r          <= IDX_W'(0);
            to_cnt_r       <= TO_W'(0);
            retry_r        <= RT_W'(0);
        end else begin
            mgmt_write     <= wr_nxt_s;
            mgmt_address   <= addr_nxt_s;
            mgmt_writedata <= data_nxt_s;
            busy           <= busy_nxt_s;
            done           <= done_nxt_s;
            error          <= error_nxt_s;
            active_mode    <= active_nxt_s;
            hold_reset     <= hold_nxt_s;
            mode_r         <= mode_nxt_s;
            idx_r          <= idx_nxt_s;
            to_cnt_r       <= to_nxt_s;
            retry_r        <= retry_nxt_s;
        end
    end

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for pll_reconfig_sequencer.
// Three modes are configured so that an out-of-range mode_sel (3) exists.
// -----------------------------------------------------------------------------
module tb_pll_reconfig_sequencer;

    localparam int NM = 3;
    localparam int NR = 8;
    localparam int AW = 6;
    localparam int DW = 32;

    logic                 refclk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic [1:0]           mode_sel = 2'd0;
    logic [NM*NR*AW-1:0]  cfg_addr;
    logic [NM*NR*DW-1:0]  cfg_data;
    logic [AW-1:0]        mgmt_address;
    logic                 mgmt_write;
    logic [DW-1:0]        mgmt_writedata;
    logic                 mgmt_waitrequest = 1'b0;
    logic                 pll_locked = 1'b1;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic [1:0]           active_mode;
    logic                 hold_reset;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [AW+DW-1:0] wr_q [$];
    int   done_cnt      = 0;
    int   hold_viol     = 0;
    int   hold_low_busy = 0;
    int   wait_left     = 0;
    bit   rand_wait     = 1'b0;
    bit   prev_held     = 1'b0;
    logic [AW-1:0] held_addr;
    logic [DW-1:0] held_data;

    pll_reconfig_sequencer #(
        .NUM_MODES   (NM),
        .NUM_REGS    (NR),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .LOCK_TIMEOUT(100),
        .LOCK_STABLE (16),
        .RETRY_MAX   (3)
    ) dut (
        .refclk          (refclk),
        .rst             (rst),
        .start           (start),
        .mode_sel        (mode_sel),
        .cfg_addr        (cfg_addr),
        .cfg_data        (cfg_data),
        .mgmt_address    (mgmt_address),
        .mgmt_write      (mgmt_write),
        .mgmt_writedata  (mgmt_writedata),
        .mgmt_waitrequest(mgmt_waitrequest),
        .pll_locked      (pll_locked),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .active_mode     (active_mode),
        .hold_reset      (hold_reset)
    );

    always #5 refclk = ~refclk;

    function automatic logic [AW-1:0] ea(input int m, input int r);
        return AW'(3 + r + 16 * m);
    endfunction

    function automatic logic [DW-1:0] ed(input int m, input int r);
        return 32'hC0DE_0000 + DW'(m * 256 + r);
    endfunction

    // Expected k-th write of one attempt for mode m
    function automatic logic [AW+DW-1:0] exp_wr(input int m, input int k);
        logic [AW+DW-1:0] v;
        if (k == 0) v = {6'd0, 32'd0};
        else if (k == NR + 1) v = {6'd2, 32'd1};
        else v = {ea(m, k - 1), ed(m, k - 1)};
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_seq(input string tag, input int m, input int reps);
        check({tag, "_count"}, 64'(wr_q.size()), 64'((NR + 2) * reps));
        for (int k = 0; k < wr_q.size() && k < (NR + 2) * reps; k++)
            check($sformatf("%s_wr%0d", tag, k), 64'(wr_q[k]), 64'(exp_wr(m, k % (NR + 2))));
    endtask

    // Waitrequest driver and bus monitor; inputs stay fixed until the next
    // rising edge, so a handshake seen here is the one that edge completes.
    always @(negedge refclk) begin
        if (rst) begin
            mgmt_waitrequest = 1'b0;
            prev_held        = 1'b0;
        end else begin
            if (rand_wait && mgmt_write && wait_left > 0) begin
                mgmt_waitrequest = 1'b1;
                wait_left--;
            end else begin
                mgmt_waitrequest = 1'b0;
                if (mgmt_write) wait_left = int'($urandom_range(0, 5));
            end
            if (prev_held && (!mgmt_write || mgmt_address !== held_addr ||
                              mgmt_writedata !== held_data))
                hold_viol++;
            prev_held = mgmt_write && mgmt_waitrequest;
            held_addr = mgmt_address;
            held_data = mgmt_writedata;
            if (mgmt_write && !mgmt_waitrequest) wr_q.push_back({mgmt_address, mgmt_writedata});
            if (done) done_cnt++;
            if (busy && !hold_reset) hold_low_busy++;
        end
    end

    initial begin
        for (int m = 0; m < NM; m++) begin
            for (int r = 0; r < NR; r++) begin
                cfg_addr[(m * NR + r) * AW +: AW] = ea(m, r);
                cfg_data[(m * NR + r) * DW +: DW] = ed(m, r);
            end
        end

        // ---------------- reset values and initial lock ----------------
        repeat (3) @(negedge refclk);
        check("rst_write",  64'(mgmt_write), 64'(0));
        check("rst_addr",   64'(mgmt_address), 64'(0));
        check("rst_data",   64'(mgmt_writedata), 64'(0));
        check("rst_busy",   64'(busy), 64'(0));
        check("rst_done",   64'(done), 64'(0));
        check("rst_error",  64'(error), 64'(0));
        check("rst_active", 64'(active_mode), 64'(0));
        check("rst_hold",   64'(hold_reset), 64'(1));
        rst = 1'b0;
        repeat (18) @(posedge refclk);
        #1;
        check("init_hold_edge18", 64'(hold_reset), 64'(1));
        @(posedge refclk);
        #1;
        check("init_hold_edge19", 64'(hold_reset), 64'(0));
        check("init_busy",   64'(busy), 64'(0));
        check("init_active", 64'(active_mode), 64'(0));

        // ---------------- mode 1, no waitrequest ----------------
        @(negedge refclk);
        wr_q.delete();
        done_cnt = 0;
        hold_low_busy = 0;
        start = 1'b1;
        mode_sel = 2'd1;
        pll_locked = 1'b0;
        @(negedge refclk);
        start = 1'b0;
        check("m1_busy",  64'(busy), 64'(1));
        check("m1_hold",  64'(hold_reset), 64'(1));
        for (int i = 0; i < 100 && wr_q.size() < NR + 2; i++) @(negedge refclk);
        repeat (20) @(negedge refclk);
        pll_locked = 1'b1;
        for (int i = 0; i < 300 && done_cnt == 0; i++) @(negedge refclk);
        check("m1_done_seen", 64'(done_cnt > 0), 64'(1));
        check("m1_hold_after_done", 64'(hold_reset), 64'(0));
        check("m1_active", 64'(active_mode), 64'(1));
        repeat (3) @(negedge refclk);
        check("m1_done_once", 64'(done_cnt), 64'(1));
        check("m1_busy_end",  64'(busy), 64'(0));
        check("m1_error",     64'(error), 64'(0));
        check("m1_hold_while_busy", 64'(hold_low_busy), 64'(0));
        check_seq("m1", 1, 1);

        // ---------------- mode 1, random waitrequest ----------------
        wr_q.delete();
        done_cnt = 0;
        hold_viol = 0;
        wait_left = 3;
        rand_wait = 1'b1;
        start = 1'b1;
        mode_sel = 2'd1;
        pll_locked = 1'b0;
        @(negedge refclk);
        start = 1'b0;
        for (int i = 0; i < 200 && wr_q.size() < NR + 2; i++) @(negedge refclk);
        repeat (20) @(negedge refclk);
        pll_locked = 1'b1;
        for (int i = 0; i < 300 && done_cnt == 0; i++) @(negedge refclk);
        repeat (3) @(negedge refclk);
        rand_wait = 1'b0;
        check("wr_done_once", 64'(done_cnt), 64'(1));
        check("wr_stable_held", 64'(hold_viol), 64'(0));
        check("wr_active", 64'(active_mode), 64'(1));
        check_seq("wr", 1, 1);

        // ---------------- out-of-range mode ----------------
        wr_q.delete();
        start = 1'b1;
        mode_sel = 2'd3;
        @(negedge refclk);
        start = 1'b0;
        repeat (5) @(negedge refclk);
        check("bad_error",  64'(error), 64'(1));
        check("bad_busy",   64'(busy), 64'(0));
        check("bad_writes", 64'(wr_q.size()), 64'(0));
        check("bad_active", 64'(active_mode), 64'(1));
        check("bad_hold",   64'(hold_reset), 64'(0));

        // ---------------- lock timeout with retries ----------------
        wr_q.delete();
        done_cnt = 0;
        hold_low_busy = 0;
        start = 1'b1;
        mode_sel = 2'd2;
        pll_locked = 1'b0;
        @(negedge refclk);
        start = 1'b0;
        check("to_error_cleared", 64'(error), 64'(0));
        check("to_busy", 64'(busy), 64'(1));
        repeat (4) @(negedge refclk);
        start = 1'b1;
        mode_sel = 2'd0;
        @(negedge refclk);
        start = 1'b0;
        for (int i = 0; i < 3000 && busy; i++) @(negedge refclk);
        check("to_busy_end", 64'(busy), 64'(0));
        check("to_error",    64'(error), 64'(1));
        check("to_hold",     64'(hold_reset), 64'(1));
        check("to_active",   64'(active_mode), 64'(1));
        check("to_no_done",  64'(done_cnt), 64'(0));
        check("to_hold_while_busy", 64'(hold_low_busy), 64'(0));
        check_seq("to", 2, 4);

        // ---------------- restart from FAIL, then reset mid-write ----------------
        wr_q.delete();
        pll_locked = 1'b1;
        start = 1'b1;
        mode_sel = 2'd0;
        @(negedge refclk);
        start = 1'b0;
        check("fail_restart_busy",  64'(busy), 64'(1));
        check("fail_restart_error", 64'(error), 64'(0));
        for (int i = 0; i < 50 && wr_q.size() < 3; i++) @(negedge refclk);
        check("mid_write_high", 64'(mgmt_write), 64'(1));
        rst = 1'b1;
        #1;
        check("mid_rst_write", 64'(mgmt_write), 64'(0));
        check("mid_rst_busy",  64'(busy), 64'(0));
        check("mid_rst_hold",  64'(hold_reset), 64'(1));
        @(negedge refclk);
        rst = 1'b0;
        repeat (2) @(posedge refclk);
        #1;
        check("post_rst_hold", 64'(hold_reset), 64'(1));
        for (int i = 0; i < 40 && hold_reset; i++) @(negedge refclk);
        check("post_rst_relock", 64'(hold_reset), 64'(0));
        check("post_rst_active", 64'(active_mode), 64'(0));
        check("post_rst_busy",   64'(busy), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
